// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier retiring BPC multiplier bits per cycle,
// signed or unsigned per operation, with valid/ready handshakes on input and output.
module seq_multiplier #(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_pp;
  logic [2*WIDTH-1:0] w_acc_next;
  // The most-negative operand negates to itself, which read unsigned is exactly 2^(WIDTH-1).
  assign w_mag_a    = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b    = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_pp       = r_mcand * {{(2*WIDTH-BPC){1'b0}}, r_mplier[BPC-1:0]};
  assign w_acc_next = r_acc + w_pp;
  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state == S_BUSY);
  assign out_valid  = (r_state == S_DONE);
  assign product    = r_product;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
          r_mplier <= w_mag_b;
          r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_acc    <= '0;
          r_cnt    <= CW'(N);
          r_state  <= S_BUSY;
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << BPC;
          r_mplier <= r_mplier >> BPC;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_product <= r_neg ? -w_acc_next : w_acc_next;
            r_state   <= S_DONE;
          end
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of seq_multiplier at 16x16/BPC=1 plus an 8-bit BPC=4 instance.
module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, is_signed = 1'b0, out_valid, out_ready = 1'b1, busy;
  logic [15:0] a = '0, b = '0;
  logic [31:0] product;
  logic        in_valid8 = 1'b0, in_ready8, is_signed8 = 1'b0, out_valid8, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] product8;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  seq_multiplier #(.WIDTH(16), .BPC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );
  seq_multiplier #(.WIDTH(8), .BPC(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .is_signed(is_signed8), .out_valid(out_valid8), .out_ready(1'b1), .product(product8), .busy(busy8)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic is, output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    a = ia; b = ib; is_signed = is; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); is_signed = ~is;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask
  task automatic op_check(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                          input logic is, input logic [31:0] exp);
    int lat;
    do_op(ia, ib, is, lat);
    check({tag, "_lat"}, 64'(lat), 64'd16);
    check(tag, 64'(product), 64'(exp));
    @(posedge clk); #1;
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
  endtask
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic is);
    int lat = 0;
    logic [15:0] exp;
    exp = is ? ({{8{ia[7]}}, ia} * {{8{ib[7]}}, ib}) : ({8'd0, ia} * {8'd0, ib});
    a8 = ia; b8 = ib; is_signed8 = is; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("w8_lat", 64'(lat), 64'd2);
    check("w8_prod", 64'(product8), 64'(exp));
    @(posedge clk); #1;
  endtask
  initial begin
    int lat, idx, oidx, cyc, last_acc;
    logic prev;
    logic [31:0] exp_p [3];
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    op_check("umax", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    op_check("s_minmin", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    op_check("s_m1x1", 16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF);
    op_check("s_m5x0", 16'hFFFB, 16'h0000, 1'b1, 32'h00000000);
    op_check("s_7xm3", 16'h0007, 16'hFFFD, 1'b1, 32'hFFFFFFEB);
    op_check("s_m1xm1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    op_check("s_minx1", 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);
    op_check("u_8000x2", 16'h8000, 16'h0002, 1'b0, 32'h00010000);
    op_check("u_mixed", 16'h1234, 16'h5678, 1'b0, 32'h06260060);
    out_ready = 1'b0;
    do_op(16'd100, 16'd200, 1'b0, lat);
    check("bp_lat", 64'(lat), 64'd16);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_prod", 64'(product), 64'h4E20);
      check("bp_hold_rdy", 64'(in_ready), 64'd0);
      check("bp_hold_vld", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_vld", 64'(out_valid), 64'd0);
    check("bp_release_rdy", 64'(in_ready), 64'd1);
    a = 16'hFFFF; b = 16'hFFFF; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_prod", 64'(product), 64'd0);
    check("mid_rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    op_check("after_rst", 16'd3, 16'd4, 1'b0, 32'd12);
    // Each op spends N cycles in BUSY plus one in DONE, so acceptances are N+2 edges apart.
    exp_p[0] = 32'd1; exp_p[1] = 32'd4; exp_p[2] = 32'd9;
    a = 16'd1; b = 16'd1; is_signed = 1'b0; in_valid = 1'b1;
    idx = 0; oidx = 0; cyc = 0; last_acc = 0;
    while (oidx < 3 && cyc < 200) begin
      prev = in_ready && in_valid;
      @(posedge clk); #1;
      cyc++;
      if (prev) begin
        if (idx > 0) check("b2b_gap", 64'(cyc - last_acc), 64'd18);
        last_acc = cyc;
        idx++;
        if (idx < 3) begin a = 16'(idx + 1); b = 16'(idx + 1); end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        check("b2b_prod", 64'(product), 64'(exp_p[oidx]));
        oidx++;
      end
    end
    in_valid = 1'b0;
    check("b2b_count", 64'(oidx), 64'd3);
    op8(8'h80, 8'h80, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0);
    op8(8'hFF, 8'h01, 1'b1);
    op8(8'h00, 8'hFB, 1'b1);
    for (int i = 0; i < 40; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
